// File: rtl/hazard_forward_scoreboard_if.sv
// ID-stage hazard query bundle: operand/destination info in, stall and forward selects out.
interface hazard_forward_scoreboard_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned PIPE_DEPTH     = 3
);
  localparam int unsigned FWD_W = $clog2(PIPE_DEPTH);

  logic                              id_valid_i;
  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] id_rs_addr_i;
  logic [NUM_SRC-1:0]                id_rs_rd_en_i;
  logic [REG_ADDR_WIDTH-1:0]         id_rd_addr_i;
  logic                              id_reg_write_i;
  logic [FWD_W-1:0]                  id_rdy_stage_i;
  logic                              hold_i;
  logic                              flush_i;
  logic                              stall_o;
  logic [NUM_SRC*FWD_W-1:0]          fwd_sel_o;
  logic [31:0]                       stall_cnt_o;

  modport master (
    output id_valid_i, id_rs_addr_i, id_rs_rd_en_i, id_rd_addr_i,
           id_reg_write_i, id_rdy_stage_i, hold_i, flush_i,
    input  stall_o, fwd_sel_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_addr_i, id_rs_rd_en_i, id_rd_addr_i,
           id_reg_write_i, id_rdy_stage_i, hold_i, flush_i,
    output stall_o, fwd_sel_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_forward_scoreboard.sv
// Shadow-pipeline RAW hazard detector with load-use stall and registered forward selects.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_forward_scoreboard #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned PIPE_DEPTH     = 3
) (
  input logic                       clk,
  input logic                       rst,
  hazard_forward_scoreboard_if.slave bus
);
  localparam int unsigned FWD_W = $clog2(PIPE_DEPTH);

  typedef struct packed {
    logic                      valid;
    logic                      wr;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [FWD_W-1:0]          rdy;
  } entry_t;

  entry_t                   pipe_q [PIPE_DEPTH];
  logic [NUM_SRC*FWD_W-1:0] fwd_sel_q;
  logic [NUM_SRC*FWD_W-1:0] sel_c;
  logic [NUM_SRC-1:0]       src_stall_c;
  logic                     stall_c;
  logic                     enter_c;
  logic [FWD_W-1:0]         rdy_norm_c;

  // Youngest-match search: scan oldest to youngest so the lowest stage overwrites.
  // A match in WB shadows nothing and needs no forward (regfile is write-through).
  always_comb begin
    sel_c       = '0;
    src_stall_c = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int k = int'(PIPE_DEPTH) - 1; k >= 0; k--) begin
        if (bus.id_rs_rd_en_i[i] && pipe_q[k].valid && pipe_q[k].wr &&
            (pipe_q[k].rd != '0) &&
            (pipe_q[k].rd == bus.id_rs_addr_i[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH])) begin
          sel_c[i*FWD_W +: FWD_W] = (k == int'(PIPE_DEPTH) - 1) ? '0 : FWD_W'(k + 1);
          src_stall_c[i]          = (k + 1) < int'(pipe_q[k].rdy);
        end
      end
    end
  end

  assign stall_c     = !rst && bus.id_valid_i && !bus.flush_i && (|src_stall_c);
  assign enter_c     = bus.id_valid_i && !bus.flush_i && !stall_c;
  assign bus.stall_o = stall_c;

  always_comb begin
    rdy_norm_c = bus.id_rdy_stage_i;
    if (bus.id_rdy_stage_i == '0)
      rdy_norm_c = FWD_W'(1);
    else if (32'(bus.id_rdy_stage_i) > PIPE_DEPTH - 1)
      rdy_norm_c = FWD_W'(PIPE_DEPTH - 1);
  end

  // Shadow pipeline advance; hold freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(PIPE_DEPTH); k++) pipe_q[k] <= '0;
      fwd_sel_q <= '0;
    end else if (!bus.hold_i) begin
      for (int k = int'(PIPE_DEPTH) - 1; k > 0; k--) pipe_q[k] <= pipe_q[k-1];
      if (enter_c) begin
        pipe_q[0] <= '{valid: 1'b1, wr: bus.id_reg_write_i,
                       rd: bus.id_rd_addr_i, rdy: rdy_norm_c};
        fwd_sel_q <= sel_c;
      end else begin
        pipe_q[0] <= '0;
        fwd_sel_q <= '0;
      end
    end
  end

  assign bus.fwd_sel_o = fwd_sel_q;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating stall-cycle counter, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (!bus.hold_i && stall_c && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.stall_cnt_o = stall_cnt_q;
`else
  assign bus.stall_cnt_o = 32'h0;
`endif
endmodule

// File: tb/tb_hazard_forward_scoreboard.sv
// Directed self-checking bench for hazard_forward_scoreboard (PIPE_DEPTH=3, NUM_SRC=2).
module tb_hazard_forward_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] exp_cnt = 32'd0;

  hazard_forward_scoreboard_if #(.REG_ADDR_WIDTH(5), .NUM_SRC(2), .PIPE_DEPTH(3)) bus ();

  hazard_forward_scoreboard #(.REG_ADDR_WIDTH(5), .NUM_SRC(2), .PIPE_DEPTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] en, input logic [4:0] rd, input logic wr,
                        input logic [1:0] rdy);
    bus.id_valid_i     = v;
    bus.id_rs_addr_i   = {rs1, rs0};
    bus.id_rs_rd_en_i  = en;
    bus.id_rd_addr_i   = rd;
    bus.id_reg_write_i = wr;
    bus.id_rdy_stage_i = rdy;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  // Counter only advances when the optional feature is built in.
  task automatic stall_edge();
`ifdef HAZARD_STALL_CNT_EN
    exp_cnt = exp_cnt + 32'd1;
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.hold_i  = 1'b0;
    bus.flush_i = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(bus.stall_o), 32'd0);
    chk("reset_fwd", 32'(bus.fwd_sel_o), 32'd0);
    chk("reset_cnt", bus.stall_cnt_o, 32'd0);
    rst = 1'b0;
    #1;

    // 1: ALU x5 then consumer rs1=x5 -> forward from MEM
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd1);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd1, 1'b0, 2'd1);
    #1 chk("t1_stall", 32'(bus.stall_o), 32'd0);
    tick();
    idle();
    #1 chk("t1_fwd", 32'(bus.fwd_sel_o), 32'h1);
    tick();
    chk("t1_fwd_clear", 32'(bus.fwd_sel_o), 32'h0);
    drain();

    // 2: load x7 then consumer rs2=x7 -> one stall, then forward from WB
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd2);
    tick();
    set_id(1'b1, 5'd0, 5'd7, 2'b10, 5'd2, 1'b1, 2'd1);
    #1 chk("t2_stall", 32'(bus.stall_o), 32'd1);
    tick();
    stall_edge();
    chk("t2_stall_gone", 32'(bus.stall_o), 32'd0);
    chk("t2_fwd_bubble", 32'(bus.fwd_sel_o), 32'h0);
    tick();
    idle();
    #1 chk("t2_fwd", 32'(bus.fwd_sel_o), 32'h8);
    chk("t2_cnt", bus.stall_cnt_o, exp_cnt);
    drain();

    // 3: two ALU writes of x3; youngest wins for both operands
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 2'd1);
    tick();
    tick();
    set_id(1'b1, 5'd3, 5'd3, 2'b11, 5'd4, 1'b0, 2'd1);
    #1 chk("t3_stall", 32'(bus.stall_o), 32'd0);
    tick();
    idle();
    #1 chk("t3_fwd", 32'(bus.fwd_sel_o), 32'h5);
    drain();

    // 4: x0 never matches
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 2'd2);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 2'b01, 5'd1, 1'b0, 2'd1);
    #1 chk("t4_stall", 32'(bus.stall_o), 32'd0);
    tick();
    idle();
    #1 chk("t4_fwd", 32'(bus.fwd_sel_o), 32'h0);
    drain();

    // rdy normalisation: 0 behaves as 1, 3 clamps to 2
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 2'd0);
    tick();
    set_id(1'b1, 5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
    #1 chk("rdy0_stall", 32'(bus.stall_o), 32'd0);
    tick();
    idle();
    #1 chk("rdy0_fwd", 32'(bus.fwd_sel_o), 32'h1);
    drain();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 2'd3);
    tick();
    set_id(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
    #1 chk("rdy3_stall", 32'(bus.stall_o), 32'd1);
    idle();
    drain();

    // 5: load x9, consumer held for 3 cycles
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 2'd2);
    tick();
    set_id(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
    bus.hold_i = 1'b1;
    #1 chk("t5_stall_hold0", 32'(bus.stall_o), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_stall_hold", 32'(bus.stall_o), 32'd1);
      chk("t5_fwd_hold", 32'(bus.fwd_sel_o), 32'h0);
    end
    chk("t5_cnt_hold", bus.stall_cnt_o, exp_cnt);
    bus.hold_i = 1'b0;
    #1 chk("t5_stall_rel", 32'(bus.stall_o), 32'd1);
    tick();
    stall_edge();
    chk("t5_stall_done", 32'(bus.stall_o), 32'd0);
    tick();
    idle();
    #1 chk("t5_fwd", 32'(bus.fwd_sel_o), 32'h2);
    chk("t5_cnt", bus.stall_cnt_o, exp_cnt);
    drain();

    // 6a: flush overrides a pending stall
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd11, 1'b1, 2'd2);
    tick();
    set_id(1'b1, 5'd11, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
    #1 chk("t6_stall_pre", 32'(bus.stall_o), 32'd1);
    bus.flush_i = 1'b1;
    #1 chk("t6_stall_flush", 32'(bus.stall_o), 32'd0);
    tick();
    bus.flush_i = 1'b0;
    chk("t6_fwd_bubble", 32'(bus.fwd_sel_o), 32'h0);
    #1 chk("t6_stall_after", 32'(bus.stall_o), 32'd0);
    tick();
    idle();
    #1 chk("t6_fwd", 32'(bus.fwd_sel_o), 32'h2);
    drain();

    // 6b: async reset mid-stream clears stall and forwards
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 2'd1);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd15, 1'b1, 2'd2);
    tick();
    set_id(1'b1, 5'd12, 5'd15, 2'b11, 5'd0, 1'b0, 2'd1);
    #1 chk("t6r_stall_pre", 32'(bus.stall_o), 32'd1);
    #1 rst = 1'b1;
    #1 chk("t6r_stall_rst", 32'(bus.stall_o), 32'd0);
    chk("t6r_fwd_rst", 32'(bus.fwd_sel_o), 32'h0);
    chk("t6r_cnt_rst", bus.stall_cnt_o, 32'd0);
    rst = 1'b0;
    #1 chk("t6r_stall_post", 32'(bus.stall_o), 32'd0);
    tick();
    idle();
    #1 chk("t6r_fwd_post", 32'(bus.fwd_sel_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
